// File: rtl/pipe4stage.sv
// Four-stage pipelined 16-bit ALU: S1 register read, S2 ALU, S3 write-back,
// S4 memory store. No forwarding or interlock; dependents must issue 3+ cycles later.
module pipe4stage (
  input  logic        clk1,
  input  logic        rst,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  rd,
  input  logic [3:0]  func,
  input  logic [7:0]  addr,
  input  logic        write,
  input  logic [7:0]  dbg_addr,
  output logic [15:0] zout,
  output logic [15:0] dbg_data
);

  logic [15:0] rf_q  [16];
  logic [15:0] mem_q [256];

  // S1
  logic        v1_q;
  logic [15:0] a1_q, b1_q;
  logic [3:0]  rd1_q, func1_q;
  logic [7:0]  addr1_q;
  // S2
  logic        v2_q;
  logic [15:0] z2_q;
  logic [3:0]  rd2_q;
  logic [7:0]  addr2_q;
  // S3
  logic        v3_q;
  logic [15:0] z3_q;
  logic [7:0]  addr3_q;

  logic [15:0] alu_d;

  always_comb begin
    alu_d = '0;
    unique case (func1_q)
      4'd0:    alu_d = a1_q + b1_q;
      4'd1:    alu_d = a1_q - b1_q;
      4'd2:    alu_d = a1_q * b1_q;
      4'd3:    alu_d = a1_q;
      4'd4:    alu_d = b1_q;
      4'd5:    alu_d = a1_q & b1_q;
      4'd6:    alu_d = a1_q | b1_q;
      4'd7:    alu_d = a1_q ^ b1_q;
      4'd8:    alu_d = ~a1_q;
      4'd9:    alu_d = ~b1_q;
      4'd10:   alu_d = a1_q >> 1;
      4'd11:   alu_d = a1_q << 1;
      default: alu_d = '0;
    endcase
  end

  // Register bank and pipeline registers; reads in S1 see pre-write-back values.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) rf_q[i] <= 16'(i);
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      rd1_q   <= '0;
      func1_q <= '0;
      addr1_q <= '0;
      v2_q    <= 1'b0;
      z2_q    <= '0;
      rd2_q   <= '0;
      addr2_q <= '0;
      v3_q    <= 1'b0;
      z3_q    <= '0;
      addr3_q <= '0;
    end else begin
      v1_q <= write;
      if (write) begin
        a1_q    <= rf_q[rs1];
        b1_q    <= rf_q[rs2];
        rd1_q   <= rd;
        func1_q <= func;
        addr1_q <= addr;
      end

      v2_q <= v1_q;
      if (v1_q) begin
        z2_q    <= alu_d;
        rd2_q   <= rd1_q;
        addr2_q <= addr1_q;
      end

      v3_q <= v2_q;
      if (v2_q) begin
        rf_q[rd2_q] <= z2_q;
        z3_q        <= z2_q;
        addr3_q     <= addr2_q;
      end
    end
  end

  // Memory is not reset, but a store is suppressed on a reset edge.
  always_ff @(posedge clk1) begin
    if (!rst && v3_q) mem_q[addr3_q] <= z3_q;
  end

  assign zout     = z2_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_pipe4stage.sv
// Directed scoreboard bench for pipe4stage: expected zout values are queued
// at issue and checked when the op reaches S2.
module tb_pipe4stage;

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
  logic [7:0]  addr = '0, dbg_addr = '0;
  logic        write = 1'b0;
  logic [15:0] zout, dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q [$];
  logic tb_v1 = 1'b0, tb_v2 = 1'b0;
  logic [15:0] last_z = '0;

  pipe4stage dut (
    .clk1(clk1), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func),
    .addr(addr), .write(write), .dbg_addr(dbg_addr), .zout(zout), .dbg_data(dbg_data)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge; tracks issue validity so the queue is popped when zout updates.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk1);
    if (rst) begin
      tb_v1 = 1'b0;
      tb_v2 = 1'b0;
      exp_q.delete();
      last_z = '0;
    end else begin
      tb_v2 = tb_v1;
      tb_v1 = write;
    end
    #1;
    if (tb_v2) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        chk("zout", zout, e);
        last_z = e;
      end
    end
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                       input logic [3:0] f, input logic [7:0] ad, input logic [15:0] e);
    rs1 = a; rs2 = b; rd = d; func = f; addr = ad; write = 1'b1;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    write = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    write = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input logic [7:0] a, input logic [15:0] e);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, e);
  endtask

  initial begin
    do_reset();
    chk("reset_zout", zout, 16'd0);

    // Basic dependent chain, each op retired before the next
    issue(4'd1, 4'd2, 4'd3, 4'd0, 8'd10, 16'd3);
    idle(4);
    chk_mem("mem10", 8'd10, 16'd3);
    issue(4'd3, 4'd1, 4'd4, 4'd1, 8'd20, 16'd2);
    idle(4);
    issue(4'd4, 4'd2, 4'd5, 4'd2, 8'd30, 16'd4);
    idle(4);
    chk_mem("mem20", 8'd20, 16'd2);
    chk_mem("mem30", 8'd30, 16'd4);
    issue(4'd3, 4'd0, 4'd15, 4'd3, 8'd31, 16'd3);  // reg3 written back
    idle(3);

    // Fresh reset; back-to-back logic ops on reset register values
    do_reset();
    issue(4'd1, 4'd2, 4'd9,  4'd5,  8'd40, 16'd0);
    issue(4'd1, 4'd2, 4'd10, 4'd6,  8'd50, 16'd3);
    issue(4'd1, 4'd2, 4'd11, 4'd7,  8'd60, 16'd3);
    issue(4'd1, 4'd2, 4'd12, 4'd8,  8'd70, 16'd65534);
    issue(4'd1, 4'd2, 4'd13, 4'd11, 8'd80, 16'd2);
    issue(4'd1, 4'd2, 4'd14, 4'd1,  8'd81, 16'hFFFF);
    issue(4'd1, 4'd2, 4'd14, 4'd9,  8'd82, 16'hFFFD);
    issue(4'd5, 4'd2, 4'd14, 4'd10, 8'd83, 16'd2);
    issue(4'd5, 4'd6, 4'd14, 4'd4,  8'd84, 16'd6);
    issue(4'd5, 4'd6, 4'd14, 4'd12, 8'd85, 16'd0);
    idle(4);
    chk_mem("mem40", 8'd40, 16'd0);
    chk_mem("mem70", 8'd70, 16'd65534);
    chk_mem("mem80", 8'd80, 16'd2);
    chk_mem("mem85", 8'd85, 16'd0);
    issue(4'd12, 4'd12, 4'd14, 4'd2, 8'd86, 16'd4);  // 0xFFFE^2 truncated
    idle(4);

    // Hazard spacing: +1 and +2 read stale reg3, +3 sees 11
    issue(4'd5, 4'd6, 4'd3, 4'd0, 8'd90, 16'd11);
    issue(4'd3, 4'd1, 4'd4, 4'd1, 8'd91, 16'd2);
    issue(4'd3, 4'd1, 4'd7, 4'd1, 8'd92, 16'd2);
    issue(4'd3, 4'd1, 4'd8, 4'd1, 8'd93, 16'd10);
    idle(4);
    chk_mem("mem91", 8'd91, 16'd2);
    chk_mem("mem93", 8'd93, 16'd10);

    // Bubbles: inputs change but write=0
    rs1 = 4'd5; rs2 = 4'd6; rd = 4'd1; func = 4'd0; addr = 8'd40;
    write = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("bubble_zout", zout, last_z);
    chk_mem("bubble_mem40", 8'd40, 16'd0);
    issue(4'd1, 4'd0, 4'd15, 4'd3, 8'd94, 16'd1);
    idle(4);

    // Reset one cycle after issue flushes the op
    issue(4'd5, 4'd6, 4'd1, 4'd0, 8'd91, 16'd11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("flush_zout", zout, 16'd0);
    idle(4);
    chk("flush_zout_hold", zout, 16'd0);
    chk_mem("flush_mem91", 8'd91, 16'd2);
    issue(4'd1, 4'd0, 4'd15, 4'd3, 8'd95, 16'd1);
    issue(4'd3, 4'd0, 4'd15, 4'd3, 8'd96, 16'd3);
    idle(4);

    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
